fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   IF stage feeding the IF/ID register. Owns the fetch PC and issues word reads to
//   instruction memory over a req/gnt + rvalid interface, one read outstanding at most.
//   Returned words go into a small instruction buffer. The buffer head drives instrF/PCPlus4F.
//   Branch/jump redirects flush the buffer and discard any in-flight response.
// PARAMETERS
//   RESET_PC   32'h0000_0000  fetch address loaded on reset
//   IBUF_DEPTH 2              instruction buffer entries (power of 2, >=2)
// PORTS
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   imem_req     out  1   read request
//   imem_addr    out  32  word-aligned read address (= fetch_pc)
//   imem_gnt     in   1   request accepted this cycle
//   imem_rvalid  in   1   read data valid, >=1 cycle after gnt
//   imem_rdata   in   32  instruction word
//   stallF       in   1   IF/ID holding; do not pop the head
//   redirect     in   1   branch/jump taken; restart fetch
//   redirect_pc  in   32  new fetch address (bits[1:0] ignored, forced 0)
//   validF       out  1   buffer head valid
//   instrF       out  32  head instruction; 32'h0 (NOP) when !validF
//   PCPlus4F     out  32  head PC + 4 (mod 2^32); 32'h0 when !validF
// BEHAVIOUR
//   Reset: fetch_pc=RESET_PC, state=IDLE, buffer empty.
//     imem_req=0, validF=0, instrF=0, PCPlus4F=0.
//     Any response outstanding at reset is forgotten; imem is reset with the core.
//   State machine:
//     IDLE: nothing outstanding.
//     WAIT: one read outstanding; its data is kept.
//     DROP: one read outstanding; its data is discarded.
//   pop  = validF & ~stallF & ~redirect; space = IBUF_DEPTH - count + pop.
//   imem_req asserted (with imem_addr = fetch_pc) when ~redirect and either:
//     state==IDLE with space>=1, or
//     state==WAIT with imem_rvalid and space>=2.
//     DROP never requests.
//   Handshake: req&gnt -> fetch_pc+=4, state=WAIT, tag of outstanding = fetch_pc.
//     While req=1 and no gnt, imem_addr is held. req drops only on redirect.
//   WAIT & rvalid & ~redirect: push {tag, rdata}. Next state is WAIT if re-granted this cycle, else IDLE.
//   Push and pop in the same cycle are both performed; count unchanged.
//     Overflow cannot occur because space is reserved at request time.
//   redirect (highest priority, same cycle):
//     buffer flushed (count=0), pop suppressed, fetch_pc<=redirect_pc & ~3.
//     Next state: IDLE if nothing outstanding or rvalid arrives this cycle; otherwise DROP.
//   DROP & rvalid: data dropped, state=IDLE. redirect while in DROP stays DROP and only updates fetch_pc.
//   Throughput: 1 instr/cycle when imem returns data the cycle after gnt and stallF=0.
//   Latency: rvalid at cycle t -> validF at t+1.
//   Outputs: instrF/PCPlus4F are driven from buffer registers. No combinational path from imem_rdata.
//   PC arithmetic: 32-bit, wraps 32'hFFFF_FFFC -> 32'h0.
// TESTING
//   1 Reset, gnt=1, rvalid 1 cycle after gnt, stallF=0
//     -> addrs 0,4,8 on consecutive cycles; validF from cycle 2; PCPlus4F 4,8,12.
//   2 stallF=1 for 5 cycles with streaming memory
//     -> buffer fills to 2, req drops, head instr/PCPlus4F stable; resumes with no loss or duplicate.
//   3 redirect to 32'h100 while read of 0x8 outstanding
//     -> state DROP, no req until rvalid; 0x8 data never appears; next addr 0x100, PCPlus4F 0x104.
//   4 redirect in the same cycle as rvalid and a pop
//     -> buffer empty next cycle, validF=0, req for redirect_pc following cycle.
//   5 gnt held low 3 cycles
//     -> req and addr stable; RESET_PC=32'hFFFF_FFFC fetch wraps next addr to 0.
//   6 rst_n low mid-WAIT
//     -> outputs 0 immediately (async), fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, keeps at most one imem read in flight,
// and queues returned words in a small buffer whose head feeds the IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IBUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stallF,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        validF,
  output logic [31:0] instrF,
  output logic [31:0] PCPlus4F
);

  localparam int PW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE   = 1;
  localparam logic [CW-1:0] CNT_ONE   = 1;
  localparam logic [CW:0]   SPACE_ONE = 1;
  localparam logic [CW:0]   SPACE_TWO = 2;
  localparam logic [CW:0]   DEPTH_EXT = IBUF_DEPTH;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   tag_q, tag_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   buf_instr_q [IBUF_DEPTH];
  logic [31:0]   buf_pc4_q   [IBUF_DEPTH];

  logic          pop, push, grant, req_ok;
  logic [CW:0]   space;

  assign validF = (count_q != '0);
  assign pop    = validF & ~stallF & ~redirect;
  assign push   = (state_q == WAIT) & imem_rvalid & ~redirect;
  // Space counts the slot freed by this cycle's pop, so a request is only made
  // when its data is guaranteed a slot on return.
  assign space  = DEPTH_EXT - {1'b0, count_q} + {{CW{1'b0}}, pop};

  always_comb begin
    req_ok = 1'b0;
    unique case (state_q)
      IDLE:    req_ok = (space >= SPACE_ONE);
      WAIT:    req_ok = imem_rvalid && (space >= SPACE_TWO);
      default: req_ok = 1'b0;
    endcase
  end

  assign imem_req  = rst_n & ~redirect & req_ok;
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req & imem_gnt;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    tag_d      = tag_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (grant) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      tag_d      = fetch_pc_q;
    end

    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      state_d    = (state_q == IDLE || imem_rvalid) ? IDLE : DROP;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (!push && pop) count_d = count_q - CNT_ONE;

      unique case (state_q)
        IDLE:    if (grant) state_d = WAIT;
        WAIT:    if (imem_rvalid) state_d = grant ? WAIT : IDLE;
        DROP:    if (imem_rvalid) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      tag_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      tag_q      <= tag_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: buffer storage has no reset; entries are only visible while count marks them valid.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr_q[wr_ptr_q] <= imem_rdata;
      buf_pc4_q[wr_ptr_q]   <= tag_q + 32'd4;
    end
  end

  assign instrF   = validF ? buf_instr_q[rd_ptr_q] : 32'h0;
  assign PCPlus4F = validF ? buf_pc4_q[rd_ptr_q]   : 32'h0;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: an imem responder plus an architectural model of the
// expected instruction stream (next PC to be consumed), directed cases then random traffic.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stallF = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        validF;
  logic [31:0] instrF;
  logic [31:0] PCPlus4F;

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stallF      (stallF),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .validF      (validF),
    .instrF      (instrF),
    .PCPlus4F    (PCPlus4F)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Reference state
  logic [31:0] exp_pc = 32'h0;
  bit          out_valid = 1'b0;
  logic [31:0] out_addr = 32'h0;
  int          out_wait = 0;
  bit          prev_wait = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  int          starve = 0;
  int          max_starve = 0;

  // Stimulus knobs
  int          gnt_mode = 0;   // 0 always, 1 random, 2 never
  int          lat_min = 1;
  int          lat_max = 1;
  bit          stall_v = 1'b0;
  bit          redir_v = 1'b0;
  logic [31:0] rpc_v = 32'h0;

  // Per-cycle samples
  bit          s_req, s_gnt, s_rvalid, s_valid;
  logic [31:0] s_addr, s_instr, s_pc4;

  task automatic step();
    bit pop;
    @(negedge clk);
    stallF      = stall_v;
    redirect    = redir_v;
    redirect_pc = rpc_v;
    imem_rvalid = out_valid && (out_wait == 0);
    imem_rdata  = imem_rvalid ? mem_word(out_addr) : $urandom;
    #1;
    case (gnt_mode)
      0:       imem_gnt = imem_req;
      1:       imem_gnt = imem_req & ($urandom_range(0, 1) == 1);
      default: imem_gnt = 1'b0;
    endcase
    #1;
    s_req = imem_req; s_gnt = imem_gnt; s_rvalid = imem_rvalid;
    s_addr = imem_addr; s_valid = validF; s_instr = instrF; s_pc4 = PCPlus4F;

    if (s_valid) begin
      check("head_instr", s_instr, mem_word(exp_pc));
      check("head_pc4", s_pc4, exp_pc + 32'd4);
    end else begin
      check("empty_instr", s_instr, 32'h0);
      check("empty_pc4", s_pc4, 32'h0);
    end
    if (redir_v) check("req_on_redirect", 32'(s_req), 32'h0);
    if (prev_wait && !redir_v) begin
      check("req_hold", 32'(s_req), 32'h1);
      check("addr_hold", s_addr, prev_addr);
    end

    pop = s_valid & ~stall_v & ~redir_v;
    if (redir_v)  exp_pc = {rpc_v[31:2], 2'b00};
    else if (pop) exp_pc = exp_pc + 32'd4;
    if (pop || redir_v || stall_v) starve = 0;
    else starve++;
    if (starve > max_starve) max_starve = starve;
    prev_wait = s_req & ~s_gnt;
    prev_addr = s_addr;

    if (s_rvalid) out_valid = 1'b0;
    else if (out_valid && out_wait > 0) out_wait--;
    if (s_req && s_gnt) begin
      check("one_outstanding", 32'(out_valid), 32'h0);
      out_valid = 1'b1;
      out_addr  = s_addr;
      out_wait  = int'($urandom_range(lat_min, lat_max)) - 1;
    end
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    redirect    = 1'b0;
    stallF      = 1'b0;
    #1;
    check("rst_validF", 32'(validF), 32'h0);
    check("rst_instrF", instrF, 32'h0);
    check("rst_pc4F", PCPlus4F, 32'h0);
    check("rst_req", 32'(imem_req), 32'h0);
    out_valid = 1'b0; prev_wait = 1'b0; exp_pc = 32'h0; starve = 0;
    stall_v = 1'b0; redir_v = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] h_instr, h_pc4;
    bit found;

    #2;
    apply_reset();

    // Streaming fetch straight out of reset
    gnt_mode = 0; lat_min = 1; lat_max = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i < 3) begin
        check("t1_req", 32'(s_req), 32'h1);
        check("t1_addr", s_addr, 32'(i * 4));
      end
      check("t1_valid", 32'(s_valid), 32'(i >= 2));
      if (i >= 2) check("t1_pc4", s_pc4, 32'((i - 1) * 4));
    end

    // Stall with streaming memory: buffer fills, req drops, head holds
    step(); step();
    stall_v = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 0) begin h_instr = s_instr; h_pc4 = s_pc4; end
      else begin
        check("t2_req_low", 32'(s_req), 32'h0);
        check("t2_head_instr", s_instr, h_instr);
        check("t2_head_pc4", s_pc4, h_pc4);
      end
    end
    stall_v = 1'b0;
    repeat (6) step();

    // Redirect while the read of 0x8 is outstanding
    lat_min = 3; lat_max = 3;
    redir_v = 1'b1; rpc_v = 32'h0; step(); redir_v = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      step();
      found = s_req && s_gnt && (s_addr == 32'h8);
    end
    check("t3_found_req8", 32'(found), 32'h1);
    redir_v = 1'b1; rpc_v = 32'h103; step(); redir_v = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      step();
      check("t3_drop_no_req", 32'(s_req), 32'h0);
      found = s_rvalid;
    end
    check("t3_drop_rvalid", 32'(found), 32'h1);
    step();
    check("t3_req", 32'(s_req), 32'h1);
    check("t3_addr", s_addr, 32'h100);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      found = s_valid;
    end
    check("t3_valid", 32'(found), 32'h1);
    check("t3_pc4", s_pc4, 32'h104);

    // Redirect coinciding with rvalid and a pop
    lat_min = 1; lat_max = 1;
    repeat (4) step();
    redir_v = 1'b1; rpc_v = 32'h200; step(); redir_v = 1'b0;
    check("t4_pre_valid", 32'(s_valid), 32'h1);
    check("t4_pre_rvalid", 32'(s_rvalid), 32'h1);
    step();
    check("t4_valid", 32'(s_valid), 32'h0);
    check("t4_req", 32'(s_req), 32'h1);
    check("t4_addr", s_addr, 32'h200);

    // Grant withheld, then PC wrap
    gnt_mode = 2;
    repeat (3) step();
    redir_v = 1'b1; rpc_v = 32'hFFFF_FFFF; step(); redir_v = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t5_req", 32'(s_req), 32'h1);
      check("t5_addr", s_addr, 32'hFFFF_FFFC);
    end
    gnt_mode = 0;
    step();
    check("t5_gnt_addr", s_addr, 32'hFFFF_FFFC);
    step();
    check("t5_wrap_req", 32'(s_req), 32'h1);
    check("t5_wrap_addr", s_addr, 32'h0);
    repeat (3) step();

    // Asynchronous reset in the middle of an outstanding read
    lat_min = 4; lat_max = 4;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      step();
      found = s_req && s_gnt;
    end
    check("t6_granted", 32'(found), 32'h1);
    @(posedge clk); #2;
    apply_reset();
    lat_min = 1; lat_max = 1;
    step();
    check("t6_req", 32'(s_req), 32'h1);
    check("t6_addr", s_addr, 32'h0);
    repeat (3) step();

    // Random traffic against the stream model
    gnt_mode = 1; lat_min = 1; lat_max = 3;
    for (int n = 0; n < 600; n++) begin
      stall_v = ($urandom_range(0, 3) == 0);
      redir_v = ($urandom_range(0, 31) == 0);
      rpc_v   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                            : ($urandom & 32'h0000_FFFF);
      step();
    end
    stall_v = 1'b0; redir_v = 1'b0;
    repeat (5) step();
    check("max_starve_over_40", 32'(max_starve > 40), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
